amp_power_sequencer: RTL and testbench

- Controller for the QLA motor-power path: sequences pwr_enable, waits for mv_good, then gates per-axis amplifier enables.
- Combines host requests with SafetyCheck trips and a host-write watchdog; latches faults until explicitly cleared.
- Sits between the BoardRegs power/amp request bits and the pwr_enable / amp_disable pins.

---
 rtl/amp_power_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_amp_power_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amp_power_sequencer.sv
// -----------------------------------------------------------------------------
// amp_power_sequencer
//
// Motor-power path controller. Raises pwr_enable on host request, waits for the
// motor supply to report good, lets it settle, then passes per-axis amplifier
// enables through while watching SafetyCheck trips, the supply-good level and
// a host-write watchdog. Faults latch in FAULT until the host drops its power
// request and pulses clear_fault.
//
// Ports:
//   sysclk          in   system clock (49.152 MHz)
//   reset           in   synchronous, active-high reset
//   pwr_req         in   host level request for motor power
//   amp_req[3:0]    in   host per-axis amp request, bit0 = axis 1
//   safety_disable  in   per-axis SafetyCheck trip (level)
//   mv_good         in   motor supply good (already synchronised)
//   wdog_en         in   watchdog enable
//   wdog_kick       in   one-cycle pulse on any host register write
//   clear_fault     in   one-cycle fault clear pulse
//   pwr_enable      out  motor supply enable
//   amp_enable[3:0] out  per-axis amp enable (inverted onto amp_disable above)
//   axis_trip[3:0]  out  sticky per-axis trip flags
//   state[2:0]      out  0 OFF, 1 PWR_WAIT, 2 SETTLE, 3 RUN, 4 FAULT
//   fault_code[1:0] out  0 none, 1 MV_TIMEOUT, 2 MV_LOST, 3 WDOG
//
// Every output is registered from the next-state decision, so it reflects a
// sampled condition one cycle later.
// -----------------------------------------------------------------------------
module amp_power_sequencer #(
  parameter int MV_TIMEOUT_CYC = 4915200,
  parameter int SETTLE_CYC     = 49152,
  parameter int WDOG_CYC       = 4915200,
  parameter int CNT_W          = 24
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             pwr_req,
  input  logic [3:0]       amp_req,
  input  logic [3:0]       safety_disable,
  input  logic             mv_good,
  input  logic             wdog_en,
  input  logic             wdog_kick,
  input  logic             clear_fault,
  output logic             pwr_enable,
  output logic [3:0]       amp_enable,
  output logic [3:0]       axis_trip,
  output logic [2:0]       state,
  output logic [1:0]       fault_code
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE       = 2'd0,
    FC_MV_TIMEOUT = 2'd1,
    FC_MV_LOST    = 2'd2,
    FC_WDOG       = 2'd3
  } fault_t;

  // Terminal counts; the counter sits at 0 on the first cycle of a state, so
  // the exit fires after exactly *_CYC cycles in that state.
  localparam logic [CNT_W-1:0] MV_LAST     = CNT_W'(MV_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST   = CNT_W'(WDOG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  fault_t           code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [3:0]       trip_q, trip_d;
  logic [3:0]       amp_q, amp_d;
  logic             pwr_q, pwr_d;
  logic             wdog_expire;
  logic             cnt_active;

  // Next-state, next-output decision.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    trip_d      = '0;
    amp_d       = '0;
    wdog_expire = wdog_en && !wdog_kick && (wdog_q == WDOG_LAST);

    case (state_q)
      ST_OFF: begin
        code_d = FC_NONE;
        if (pwr_req) state_d = ST_PWR_WAIT;
      end

      ST_PWR_WAIT: begin
        if (!pwr_req) begin
          state_d = ST_OFF;
        end else if (mv_good) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == MV_LAST) begin
          state_d = ST_FAULT;
          code_d  = FC_MV_TIMEOUT;
        end
      end

      ST_SETTLE: begin
        if (!pwr_req) begin
          state_d = ST_OFF;
        end else if (!mv_good) begin
          state_d = ST_FAULT;
          code_d  = FC_MV_LOST;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!mv_good) begin
          state_d = ST_FAULT;
          code_d  = FC_MV_LOST;
        end else if (wdog_expire) begin
          state_d = ST_FAULT;
          code_d  = FC_WDOG;
        end else if (!pwr_req) begin
          state_d = ST_OFF;
        end else begin
          // A trip stays set until the host withdraws that axis' request.
          trip_d = (trip_q | safety_disable) & amp_req;
          amp_d  = amp_req & ~trip_d;
        end
      end

      ST_FAULT: begin
        // Clear is only honoured with the request dropped, so power cannot
        // bounce straight back on.
        if (clear_fault && !pwr_req) begin
          state_d = ST_OFF;
          code_d  = FC_NONE;
        end
      end

      default: begin
        state_d = ST_FAULT;
        code_d  = FC_NONE;
      end
    endcase
  end

  // Shared sequencing counter: runs only while staying in PWR_WAIT or SETTLE,
  // otherwise held at 0 so every entry starts from 0. Saturates, never wraps.
  assign cnt_active = (state_d == state_q) &&
                      ((state_q == ST_PWR_WAIT) || (state_q == ST_SETTLE));

  always_comb begin
    cnt_d = '0;
    if (cnt_active) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  end

  // Watchdog counter: only live while remaining in RUN with the watchdog
  // enabled; a kick (even on the terminal cycle) restarts it from 0.
  always_comb begin
    wdog_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && wdog_en && !wdog_kick)
      wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + CNT_ONE;
  end

  assign pwr_d = (state_d == ST_PWR_WAIT) || (state_d == ST_SETTLE) ||
                 (state_d == ST_RUN);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ST_OFF;
      code_q  <= FC_NONE;
      cnt_q   <= '0;
      wdog_q  <= '0;
      trip_q  <= '0;
      amp_q   <= '0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      trip_q  <= trip_d;
      amp_q   <= amp_d;
      pwr_q   <= pwr_d;
    end
  end

  assign pwr_enable = pwr_q;
  assign amp_enable = amp_q;
  assign axis_trip  = trip_q;
  assign state      = state_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_amp_power_sequencer.sv
// -----------------------------------------------------------------------------
// tb_amp_power_sequencer
//
// Directed bench for amp_power_sequencer with short timeouts
// (MV_TIMEOUT_CYC=100, SETTLE_CYC=20, WDOG_CYC=50). Inputs are driven and
// outputs sampled 1 time unit after each rising edge. "tN" below means the
// cycle following edge N: an input set at tN is sampled at edge N+1 and the
// resulting registered output is visible at tN+1.
// -----------------------------------------------------------------------------
module tb_amp_power_sequencer;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       pwr_req;
  logic [3:0] amp_req;
  logic [3:0] safety_disable;
  logic       mv_good;
  logic       wdog_en;
  logic       wdog_kick;
  logic       clear_fault;
  logic       pwr_enable;
  logic [3:0] amp_enable;
  logic [3:0] axis_trip;
  logic [2:0] state;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  amp_power_sequencer #(
    .MV_TIMEOUT_CYC(100),
    .SETTLE_CYC    (20),
    .WDOG_CYC      (50),
    .CNT_W         (24)
  ) dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .pwr_req       (pwr_req),
    .amp_req       (amp_req),
    .safety_disable(safety_disable),
    .mv_good       (mv_good),
    .wdog_en       (wdog_en),
    .wdog_kick     (wdog_kick),
    .clear_fault   (clear_fault),
    .pwr_enable    (pwr_enable),
    .amp_enable    (amp_enable),
    .axis_trip     (axis_trip),
    .state         (state),
    .fault_code    (fault_code)
  );

  // Packed view of every output: {pwr_enable, amp_enable, axis_trip, state, fault_code}
  wire [13:0] all_out = {pwr_enable, amp_enable, axis_trip, state, fault_code};

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; pwr_req = 1'b0; amp_req = 4'h0; safety_disable = 4'h0;
    mv_good = 1'b0; wdog_en = 1'b0; wdog_kick = 1'b0; clear_fault = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  // Drive straight to RUN with all axes requested; bounded wait.
  task automatic bring_up();
    int n;
    apply_reset();
    pwr_req = 1'b1; amp_req = 4'hF; mv_good = 1'b1;
    n = 0;
    while (!(state === 3'd3 && amp_enable === 4'hF) && n < 100) begin
      tick(1);
      n++;
    end
    checks++;
    if (state !== 3'd3 || amp_enable !== 4'hF) begin
      errors++;
      $display("FAIL bring_up: state=%0d amp_enable=%h, expected 3 / f within 100 cycles", state, amp_enable);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pwr_req = 1'b1; amp_req = 4'hF; safety_disable = 4'hF;
    mv_good = 1'b1; wdog_en = 1'b1; wdog_kick = 1'b0; clear_fault = 1'b0;
    tick(2);
    checks++;
    if (all_out !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0000", all_out);
    end
    apply_reset();
  endtask

  task automatic test_power_up();
    apply_reset();
    pwr_req = 1'b1; amp_req = 4'hF;                   // t0
    tick(1);                                          // t0+1
    checks++;
    if (pwr_enable !== 1'b1 || state !== 3'd1) begin
      errors++;
      $display("FAIL pwrup_t1: pwr_enable=%b state=%0d expected 1 / 1", pwr_enable, state);
    end
    tick(9);                                          // t0+10
    checks++;
    if (state !== 3'd1 || amp_enable !== 4'h0) begin
      errors++;
      $display("FAIL pwrup_wait: state=%0d amp_enable=%h expected 1 / 0", state, amp_enable);
    end
    mv_good = 1'b1;
    tick(1);                                          // t0+11
    checks++;
    if (state !== 3'd2 || pwr_enable !== 1'b1) begin
      errors++;
      $display("FAIL pwrup_settle: state=%0d pwr_enable=%b expected 2 / 1", state, pwr_enable);
    end
    tick(19);                                         // t0+30
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL pwrup_settle_hold: state=%0d expected 2", state);
    end
    tick(1);                                          // t0+31
    checks++;
    if (amp_enable !== 4'h0) begin
      errors++;
      $display("FAIL pwrup_t31_amp: amp_enable=%h expected 0", amp_enable);
    end
    tick(1);                                          // t0+32
    checks++;
    if (state !== 3'd3 || amp_enable !== 4'hF || pwr_enable !== 1'b1) begin
      errors++;
      $display("FAIL pwrup_run: state=%0d amp_enable=%h pwr_enable=%b expected 3 / f / 1", state, amp_enable, pwr_enable);
    end
  endtask

  task automatic test_mv_timeout();
    apply_reset();
    pwr_req = 1'b1; mv_good = 1'b0;
    tick(1);                                          // PWR_WAIT entry E
    tick(99);                                         // E+99
    checks++;
    if (state !== 3'd1 || pwr_enable !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: state=%0d pwr_enable=%b expected 1 / 1", state, pwr_enable);
    end
    tick(1);                                          // E+100
    checks++;
    if ({state, fault_code, pwr_enable, amp_enable} !== {3'd4, 2'd1, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL timeout_fault: state=%0d code=%0d pwr=%b amp=%h expected 4/1/0/0", state, fault_code, pwr_enable, amp_enable);
    end
    clear_fault = 1'b1;                               // ignored: pwr_req still 1
    tick(1);
    clear_fault = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd4 || fault_code !== 2'd1) begin
      errors++;
      $display("FAIL clear_ignored: state=%0d code=%0d expected 4 / 1", state, fault_code);
    end
    pwr_req = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd4 || fault_code !== 2'd1) begin
      errors++;
      $display("FAIL fault_hold: state=%0d code=%0d expected 4 / 1", state, fault_code);
    end
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    checks++;
    if (state !== 3'd0 || fault_code !== 2'd0) begin
      errors++;
      $display("FAIL clear_ok: state=%0d code=%0d expected 0 / 0", state, fault_code);
    end
  endtask

  task automatic test_safety_trip();
    bring_up();
    safety_disable = 4'b0100;
    tick(1);
    safety_disable = 4'b0000;
    checks++;
    if (amp_enable !== 4'hB || axis_trip !== 4'h4) begin
      errors++;
      $display("FAIL trip_drop: amp_enable=%h axis_trip=%h expected b / 4", amp_enable, axis_trip);
    end
    tick(3);
    checks++;
    if (amp_enable !== 4'hB || axis_trip !== 4'h4 || state !== 3'd3) begin
      errors++;
      $display("FAIL trip_sticky: amp_enable=%h axis_trip=%h state=%0d expected b / 4 / 3", amp_enable, axis_trip, state);
    end
    amp_req = 4'hB;
    tick(1);
    checks++;
    if (amp_enable !== 4'hB || axis_trip !== 4'h0) begin
      errors++;
      $display("FAIL trip_release: amp_enable=%h axis_trip=%h expected b / 0", amp_enable, axis_trip);
    end
    amp_req = 4'hF;
    tick(1);
    checks++;
    if (amp_enable !== 4'hF || axis_trip !== 4'h0) begin
      errors++;
      $display("FAIL trip_restore: amp_enable=%h axis_trip=%h expected f / 0", amp_enable, axis_trip);
    end
    safety_disable = 4'b0001;                         // trip axis 1, then drop power
    tick(1);
    checks++;
    if (amp_enable !== 4'hE || axis_trip !== 4'h1) begin
      errors++;
      $display("FAIL trip_axis1: amp_enable=%h axis_trip=%h expected e / 1", amp_enable, axis_trip);
    end
    pwr_req = 1'b0;
    tick(1);
    safety_disable = 4'b0000;
    checks++;
    if (all_out !== 14'h0) begin
      errors++;
      $display("FAIL run_to_off: outputs=%h expected 0000", all_out);
    end
  endtask

  task automatic test_watchdog();
    bring_up();
    wdog_en = 1'b1;
    for (int i = 0; i < 21; i++) begin                // kick every 49 cycles
      tick(48);
      wdog_kick = 1'b1;
      tick(1);
      wdog_kick = 1'b0;
      checks++;
      if (state !== 3'd3) begin
        errors++;
        $display("FAIL wdog_kicked_%0d: state=%0d expected 3", i, state);
      end
    end
    tick(49);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL wdog_pre_expiry: state=%0d expected 3", state);
    end
    tick(1);                                          // 50th cycle without a kick
    checks++;
    if ({state, fault_code, pwr_enable, amp_enable} !== {3'd4, 2'd3, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL wdog_expire: state=%0d code=%0d pwr=%b amp=%h expected 4/3/0/0", state, fault_code, pwr_enable, amp_enable);
    end

    bring_up();
    wdog_en = 1'b1;
    tick(49);
    wdog_kick = 1'b1;                                 // coincides with terminal count
    tick(1);
    wdog_kick = 1'b0;
    checks++;
    if (state !== 3'd3 || fault_code !== 2'd0) begin
      errors++;
      $display("FAIL wdog_kick_terminal: state=%0d code=%0d expected 3 / 0", state, fault_code);
    end
    tick(49);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL wdog_restart_hold: state=%0d expected 3", state);
    end
    tick(1);
    checks++;
    if (state !== 3'd4 || fault_code !== 2'd3) begin
      errors++;
      $display("FAIL wdog_restart_expire: state=%0d code=%0d expected 4 / 3", state, fault_code);
    end
  endtask

  task automatic test_priority();
    bring_up();
    wdog_en = 1'b1;
    tick(49);
    mv_good = 1'b0;                                   // same cycle as watchdog expiry
    tick(1);
    checks++;
    if (state !== 3'd4 || fault_code !== 2'd2) begin
      errors++;
      $display("FAIL priority_mv_lost: state=%0d code=%0d expected 4 / 2", state, fault_code);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    pwr_req = 1'b1; mv_good = 1'b1;
    tick(3);
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL mid_in_settle: state=%0d expected 2", state);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if (all_out !== 14'h0) begin
      errors++;
      $display("FAIL reset_from_settle: outputs=%h expected 0000", all_out);
    end
    reset = 1'b0;
    tick(2);                                          // PWR_WAIT then SETTLE
    mv_good = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd4 || fault_code !== 2'd2) begin
      errors++;
      $display("FAIL settle_mv_lost: state=%0d code=%0d expected 4 / 2", state, fault_code);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if (all_out !== 14'h0) begin
      errors++;
      $display("FAIL reset_from_fault: outputs=%h expected 0000", all_out);
    end
    reset = 1'b0;
    pwr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: time limit reached, expected $finish earlier");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_power_up();
    test_mv_timeout();
    test_safety_trip();
    test_watchdog();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
